// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store with RISC-V byte/half/word
// lanes and a fixed response latency. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_DATA,
  output logic              RSP_ERR,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic              req_fault;

  logic        cap_we, cap_uns;
  logic [1:0]  cap_size, cap_lane;
  logic [31:0] cap_word;

  logic        src_we, src_uns, src_fault;
  logic [1:0]  src_size, src_lane;
  logic [31:0] src_word, ext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign accept   = (state == IDLE) && REQ_VALID;
  assign word_idx = REQ_ADDR[ADDR_W-1:2];

  assign REQ_READY = (state == IDLE);
  assign RSP_VALID = (state == RESP);
  assign BUSY      = (state != IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction
  assign req_fault = is_misaligned(REQ_FUNCT3[1:0], REQ_ADDR[1:0]);
  assign src_fault = is_misaligned(src_size, src_lane);
`else
  assign req_fault = 1'b0;
  assign src_fault = 1'b0;
`endif

  // Store lane steering: data replicated so each enabled byte sees its slice.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_en    = 4'b0000;
    wdata_lane = REQ_WDATA;
    case (REQ_FUNCT3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << REQ_ADDR[1:0];
        wdata_lane = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        byte_en    = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{REQ_WDATA[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the memory array has no reset; only control state is reset.
  always_ff @(posedge CLK) begin
    if (accept && REQ_WE && !req_fault && !RST) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // In IDLE the live request feeds the extender so LATENCY==1 can respond directly.
  always_comb begin
    src_we   = cap_we;
    src_uns  = cap_uns;
    src_size = cap_size;
    src_lane = cap_lane;
    src_word = cap_word;
    if (state == IDLE) begin
      src_we   = REQ_WE;
      src_uns  = REQ_FUNCT3[2];
      src_size = REQ_FUNCT3[1:0];
      src_lane = REQ_ADDR[1:0];
      src_word = mem[word_idx];
    end
  end

  always_comb begin
    sel_byte = src_word[{src_lane, 3'b000} +: 8];
    sel_half = src_lane[1] ? src_word[31:16] : src_word[15:0];
    case (src_size)
      2'b00:   ext = {{24{~src_uns & sel_byte[7]}}, sel_byte};
      2'b01:   ext = {{16{~src_uns & sel_half[15]}}, sel_half};
      default: ext = src_word;
    endcase
    if (src_we || src_fault) ext = 32'h0;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_we   <= 1'b0;
      cap_uns  <= 1'b0;
      cap_size <= 2'b00;
      cap_lane <= 2'b00;
      cap_word <= 32'h0;
      RSP_DATA <= 32'h0;
      RSP_ERR  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_we   <= REQ_WE;
        cap_uns  <= REQ_FUNCT3[2];
        cap_size <= REQ_FUNCT3[1:0];
        cap_lane <= REQ_ADDR[1:0];
        cap_word <= mem[word_idx];
      end
      // Result is loaded on the edge entering RESP and held until the next response.
      if (state_nx == RESP && state != RESP) begin
        RSP_DATA <= ext;
        RSP_ERR  <= src_fault;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 instance for data paths,
// LATENCY=3 instance for the held-valid throughput pattern.
module tb_dmem_responder;

  localparam int LAT2 = 2;
  localparam int LAT3 = 3;

  logic        CLK = 1'b0;
  logic        RST;

  logic        REQ_VALID, REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [6:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        REQ_READY, RSP_VALID, RSP_ERR, BUSY;
  logic [31:0] RSP_DATA;

  logic        v3, we3;
  logic [2:0]  f3_3;
  logic [6:0]  a3;
  logic [31:0] wd3;
  logic        ready3, valid3, err3, busy3;
  logic [31:0] data3;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_W(7), .LATENCY(LAT2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  dmem_responder #(.ADDR_W(7), .LATENCY(LAT3)) dut_l3 (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(v3), .REQ_READY(ready3), .REQ_WE(we3),
    .REQ_FUNCT3(f3_3), .REQ_ADDR(a3), .REQ_WDATA(wd3),
    .RSP_VALID(valid3), .RSP_DATA(data3), .RSP_ERR(err3), .BUSY(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request on the LATENCY=2 instance and return at the first negedge after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                       input string tag);
    int w;
    exp_t e;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
    w = 0;
    while (!REQ_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (!REQ_READY) chk({tag, " accept timeout"}, 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    e.data = exp_d; e.err = exp_e; e.tag = tag;
    sb.push_back(e);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk({tag, " busy"}, {REQ_READY, BUSY}, 32'b01);
  endtask

  task automatic await_rsp();
    int   k;
    exp_t e;
    k = 1;
    while (!RSP_VALID && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " valid"}, 32'(RSP_VALID), 32'd1);
      chk({e.tag, " latency"}, 32'(k), 32'(LAT2));
      chk({e.tag, " data"}, RSP_DATA, e.data);
      chk({e.tag, " err"}, 32'(RSP_ERR), 32'(e.err));
      @(negedge CLK);
      chk({e.tag, " one-shot/ready"}, {RSP_VALID, REQ_READY}, 32'b01);
      chk({e.tag, " hold"}, RSP_DATA, e.data);
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input string tag);
    issue(we, f3, addr, wd, exp_d, exp_e, tag);
    await_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsp, pulses;
    RST = 1'b1;
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b000; REQ_ADDR = '0; REQ_WDATA = '0;
    v3 = 1'b0; we3 = 1'b0; f3_3 = 3'b000; a3 = '0; wd3 = '0;
    #1;
    chk("reset ready/valid/err/busy", {REQ_READY, RSP_VALID, RSP_ERR, BUSY}, 32'b1000);
    chk("reset data", RSP_DATA, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // word store/load and latency
    req(1'b1, 3'b010, 7'h08, 32'hDEADBEEF, 32'h0, 1'b0, "sw 08");
    req(1'b0, 3'b010, 7'h08, 32'h0, 32'hDEADBEEF, 1'b0, "lw 08");

    // sign/zero extension and lane select
    req(1'b1, 3'b010, 7'h10, 32'h8070F0A5, 32'h0, 1'b0, "sw 10");
    req(1'b0, 3'b000, 7'h10, 32'h0, 32'hFFFFFFA5, 1'b0, "lb 10");
    req(1'b0, 3'b100, 7'h10, 32'h0, 32'h000000A5, 1'b0, "lbu 10");
    req(1'b0, 3'b001, 7'h12, 32'h0, 32'hFFFF8070, 1'b0, "lh 12");
    req(1'b0, 3'b101, 7'h12, 32'h0, 32'h00008070, 1'b0, "lhu 12");
    req(1'b0, 3'b000, 7'h11, 32'h0, 32'hFFFFFFF0, 1'b0, "lb 11");
    req(1'b0, 3'b100, 7'h13, 32'h0, 32'h00000080, 1'b0, "lbu 13");

    // partial stores leave other bytes untouched
    req(1'b1, 3'b010, 7'h04, 32'h11223344, 32'h0, 1'b0, "sw 04");
    req(1'b1, 3'b000, 7'h05, 32'h000000AB, 32'h0, 1'b0, "sb 05");
    req(1'b0, 3'b010, 7'h04, 32'h0, 32'h1122AB44, 1'b0, "lw 04 after sb");
    req(1'b1, 3'b001, 7'h06, 32'h0000CAFE, 32'h0, 1'b0, "sh 06");
    req(1'b0, 3'b010, 7'h04, 32'h0, 32'hCAFEAB44, 1'b0, "lw 04 after sh");

    // reset during WAIT drops the response but keeps the committed store
    issue(1'b1, 3'b010, 7'h20, 32'h5A5AC3C3, 32'h0, 1'b0, "sw 20 reset");
    void'(sb.pop_back());
    RST = 1'b1;
    #1;
    chk("mid-reset ready/valid/busy", {REQ_READY, RSP_VALID, BUSY}, 32'b100);
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (RSP_VALID) pulses++;
      @(negedge CLK);
    end
    chk("dropped response pulses", 32'(pulses), 32'd0);
    req(1'b0, 3'b010, 7'h20, 32'h0, 32'h5A5AC3C3, 1'b0, "lw 20 after reset");

    // misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    req(1'b1, 3'b010, 7'h09, 32'h12345678, 32'h0, 1'b1, "sw 09 trap");
    req(1'b0, 3'b010, 7'h08, 32'h0, 32'hDEADBEEF, 1'b0, "lw 08 unchanged");
    req(1'b0, 3'b001, 7'h11, 32'h0, 32'h0, 1'b1, "lh 11 trap");
`else
    req(1'b1, 3'b010, 7'h09, 32'h12345678, 32'h0, 1'b0, "sw 09 aligned-down");
    req(1'b0, 3'b010, 7'h08, 32'h0, 32'h12345678, 1'b0, "lw 08 overwritten");
    req(1'b0, 3'b001, 7'h11, 32'h0, 32'hFFFFF0A5, 1'b0, "lh 11 low half");
`endif

    // held-valid throughput on the LATENCY=3 instance: one acceptance every 4 cycles
    @(negedge CLK);
    v3 = 1'b1; we3 = 1'b1; f3_3 = 3'b010; a3 = 7'h00; wd3 = 32'h77;
    acc = 0;
    rsp = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("l3 ready c%0d", i), 32'(ready3), 32'((i % 4) == 0));
      chk($sformatf("l3 valid c%0d", i), 32'(valid3), 32'((i % 4) == 3));
      if (ready3) acc++;
      if (valid3) begin
        rsp++;
        chk($sformatf("l3 store data c%0d", i), data3, 32'h0);
      end
      if (i == 11) v3 = 1'b0;
      @(negedge CLK);
    end
    chk("l3 acceptances", 32'(acc), 32'd3);
    chk("l3 responses", 32'(rsp), 32'd3);
    chk("l3 idle after", {ready3, busy3}, 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
